// File: rtl/fpu_pkg.sv
// fpu_pkg: shared floating-point datapath defaults.
//  NF_DEFAULT     fraction bits of the widest format
//  NE_DEFAULT     exponent bits of the widest format
//  WIDTH_DEFAULT  sum/addend width used by the LZA and normalizer (3*NF+6)
//  cw_of()        width of a shift count able to express 0..width inclusive
package fpu_pkg;

  localparam int NF_DEFAULT    = 52;
  localparam int NE_DEFAULT    = 11;
  localparam int WIDTH_DEFAULT = 3 * NF_DEFAULT + 6;

  // A count of WIDTH must be representable (fully-shifted-out case), hence +1.
  function automatic int cw_of(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/fmanormshift.sv
// fmanormshift: combinational normalization shifter.
//  Left-shifts the sum magnitude by the LZA count and applies the one-position
//  correction when the LZA under-counted by one.
// Ports:
//  Sm       in   WIDTH  positive sum magnitude
//  SCnt     in   CW     LZA shift count
//  Mf       out  WIDTH  normalized mantissa (0 when Sm==0 or SCnt>=WIDTH)
//  Corr     out  1      extra single-position shift was applied
//  SumZero  out  1      Sm was all zeros
module fmanormshift
  import fpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  localparam int CW   = cw_of(WIDTH)
) (
  input  logic [WIDTH-1:0] Sm,
  input  logic [CW-1:0]    SCnt,
  output logic [WIDTH-1:0] Mf,
  output logic             Corr,
  output logic             SumZero
);

  localparam logic [CW-1:0] WIDTH_CNT = CW'(WIDTH);

  // Logarithmic barrel shifter: stage gi shifts by 2**gi when SCnt[gi] is set.
  logic [CW:0][WIDTH-1:0] stage;
  logic [WIDTH-1:0]       sh;
  logic                   over_range;

  assign stage[0] = Sm;

  genvar gi;
  generate
    for (gi = 0; gi < CW; gi++) begin : g_shift
      localparam int AMT = 1 << gi;
      if (AMT >= WIDTH) begin : g_full
        assign stage[gi+1] = SCnt[gi] ? '0 : stage[gi];
      end else begin : g_part
        assign stage[gi+1] = SCnt[gi] ? {stage[gi][WIDTH-1-AMT:0], {AMT{1'b0}}}
                                      : stage[gi];
      end
    end
  endgenerate

  // Counts of WIDTH or more shift everything out.
  assign over_range = (SCnt >= WIDTH_CNT);
  assign sh         = over_range ? '0 : stage[CW];

  // LZA may be one short: a nonzero result whose MSB is still clear.
  assign Corr    = ~sh[WIDTH-1] & (|sh);
  assign Mf      = Corr ? {sh[WIDTH-2:0], 1'b0} : sh;
  assign SumZero = ~(|Sm);

endmodule

// File: rtl/fmanormpipe.sv
// fmanormpipe: two-stage pipelined FMA normalization with valid/ready handshake.
//  Stage 1 registers the sum, LZA count and preliminary exponent; stage 2
//  registers the normalized mantissa, adjusted exponent and zero flag.
// Ports:
//  clk       in   1      clock
//  resetn    in   1      asynchronous active-low reset
//  Flush     in   1      synchronous flush, clears both valid bits
//  InValid   in   1      upstream data valid
//  InReady   out  1      stage 1 can accept (combinational from OutReady)
//  Sm        in   WIDTH  positive sum magnitude
//  SCnt      in   CW     LZA shift count
//  Se        in   NE+2   preliminary biased exponent (signed)
//  OutValid  out  1      result valid
//  OutReady  in   1      downstream accepts result
//  Mf        out  WIDTH  normalized mantissa
//  Me        out  NE+2   adjusted exponent (signed, wraparound)
//  SumZero   out  1      Sm was zero
module fmanormpipe
  import fpu_pkg::*;
#(
  parameter int NF    = NF_DEFAULT,
  parameter int NE    = NE_DEFAULT,
  parameter int WIDTH = 3 * NF + 6,
  localparam int CW   = cw_of(WIDTH),
  localparam int EW   = NE + 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] Sm,
  input  logic [CW-1:0]    SCnt,
  input  logic [EW-1:0]    Se,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Mf,
  output logic [EW-1:0]    Me,
  output logic             SumZero
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_sm;
  logic [CW-1:0]    s1_scnt;
  logic [EW-1:0]    s1_se;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_mf;
  logic [EW-1:0]    s2_me;
  logic             s2_zero;

  logic             ready1;
  logic             ready2;
  logic             in_xfer;
  logic             mid_xfer;
  logic             out_xfer;

  logic [WIDTH-1:0] norm_mf;
  logic             norm_corr;
  logic             norm_zero;
  logic [EW-1:0]    norm_me;

  // Handshake: each stage is ready when empty or when the next one drains.
  assign ready2   = ~s2_valid | OutReady;
  assign ready1   = ~s1_valid | ready2;
  assign in_xfer  = InValid & ready1;
  assign mid_xfer = s1_valid & ready2;
  assign out_xfer = s2_valid & OutReady;

  fmanormshift #(
    .WIDTH (WIDTH)
  ) u_shift (
    .Sm      (s1_sm),
    .SCnt    (s1_scnt),
    .Mf      (norm_mf),
    .Corr    (norm_corr),
    .SumZero (norm_zero)
  );

  // Exponent drops by the total shift; wraps in EW bits, underflow is the
  // rounder's problem. A zero sum reports a zero exponent.
  assign norm_me = norm_zero ? '0
                 : (s1_se - EW'(s1_scnt) - EW'(norm_corr));

  // Valid bits; flush wins over any transfer in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (Flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (in_xfer)       s1_valid <= 1'b1;
      else if (mid_xfer) s1_valid <= 1'b0;

      if (mid_xfer)      s2_valid <= 1'b1;
      else if (out_xfer) s2_valid <= 1'b0;
    end
  end

  // Stage 1 data: loads only on an accepted input; a flush leaves it alone.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_sm   <= '0;
      s1_scnt <= '0;
      s1_se   <= '0;
    end else if (in_xfer && !Flush) begin
      s1_sm   <= Sm;
      s1_scnt <= SCnt;
      s1_se   <= Se;
    end
  end

  // Stage 2 data: loads on the stage 1 -> stage 2 transfer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s2_mf   <= '0;
      s2_me   <= '0;
      s2_zero <= 1'b0;
    end else if (mid_xfer && !Flush) begin
      s2_mf   <= norm_mf;
      s2_me   <= norm_me;
      s2_zero <= norm_zero;
    end
  end

  assign InReady  = ready1;
  assign OutValid = s2_valid;
  assign Mf       = s2_mf;
  assign Me       = s2_me;
  assign SumZero  = s2_zero;

  // Simulation check: any valid nonzero result must be normalized.
  norm_msb_set: assert property (
    @(posedge clk) disable iff (!resetn)
    (OutValid && !SumZero) |-> Mf[WIDTH-1]
  );

endmodule

// File: tb/tb_fmanormpipe.sv
// tb_fmanormpipe: self-checking bench for fmanormpipe at WIDTH=16, NE=8.
//  Directed table, stall/flush/reset sequences and randomized traffic checked
//  by a scoreboard fed from a normalize-by-leading-zero reference model.
module tb_fmanormpipe;

  localparam int W  = 16;
  localparam int NE = 8;
  localparam int EW = NE + 2;
  localparam int CW = 5;

  logic          clk      = 1'b0;
  logic          resetn   = 1'b1;
  logic          Flush    = 1'b0;
  logic          InValid  = 1'b0;
  logic          OutReady = 1'b0;
  logic [W-1:0]  Sm       = '0;
  logic [CW-1:0] SCnt     = '0;
  logic [EW-1:0] Se       = '0;
  logic          InReady;
  logic          OutValid;
  logic [W-1:0]  Mf;
  logic [EW-1:0] Me;
  logic          SumZero;

  always #5 clk = ~clk;

  fmanormpipe #(.NE(NE), .WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .Flush(Flush),
    .InValid(InValid), .InReady(InReady),
    .Sm(Sm), .SCnt(SCnt), .Se(Se),
    .OutValid(OutValid), .OutReady(OutReady),
    .Mf(Mf), .Me(Me), .SumZero(SumZero)
  );

  typedef struct packed {
    logic [W-1:0]  mf;
    logic [EW-1:0] me;
    logic          zero;
  } res_t;

  typedef struct {
    logic [W-1:0]  sm;
    logic [CW-1:0] scnt;
    logic [EW-1:0] se;
    logic [W-1:0]  mf;
    logic [EW-1:0] me;
    logic          zero;
  } vec_t;

  res_t exp_q[$];
  res_t mon_e;
  int   n_checks  = 0;
  int   n_err     = 0;
  int   out_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: normalizing means shifting out exactly the leading zeros, and
  // the exponent drops by that same amount (mod 2**EW).
  function automatic res_t model(input logic [W-1:0] sm, input logic [EW-1:0] se);
    res_t r;
    int   lz;
    r = '0;
    if (sm == '0) begin
      r.zero = 1'b1;
      return r;
    end
    lz = 0;
    while (sm[W-1-lz] == 1'b0) lz++;
    r.mf = sm << lz;
    r.me = se - EW'(lz);
    return r;
  endfunction

  // Random operand with a legal LZA count (exact, or one short).
  task automatic rand_op(output logic [W-1:0] sm, output logic [CW-1:0] scnt,
                         output logic [EW-1:0] se);
    int k;
    int lz;
    k  = $urandom_range(0, W);
    sm = W'($urandom) & W'((32'h1 << k) - 1);
    if (sm == '0) begin
      scnt = CW'($urandom_range(0, W));
    end else begin
      lz = 0;
      while (sm[W-1-lz] == 1'b0) lz++;
      scnt = (lz > 0 && $urandom_range(0, 1) == 1) ? CW'(lz - 1) : CW'(lz);
    end
    se = EW'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: one line per consumed output transaction.
  always @(negedge clk) begin
    if (!resetn) begin
      exp_q.delete();
    end else begin
      if (OutValid && OutReady) begin
        out_count++;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_output", 32'(OutValid), 32'(0));
        end else begin
          mon_e = exp_q.pop_front();
          $display("out #%0d: Mf=%h Me=%h SumZero=%0d (exp %h %h %0d)",
                   out_count, Mf, Me, SumZero, mon_e.mf, mon_e.me, mon_e.zero);
          check("sb_mf", 32'(Mf), 32'(mon_e.mf));
          check("sb_me", 32'(Me), 32'(mon_e.me));
          check("sb_zero", 32'(SumZero), 32'(mon_e.zero));
        end
      end
      if (Flush) exp_q.delete();
      else if (InValid && InReady) exp_q.push_back(model(Sm, Se));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t          vecs[9];
  bit            found;
  logic [W-1:0]  held_mf;
  logic [EW-1:0] held_me;
  int            cnt0;
  logic [W-1:0]  o_sm[4];
  logic [CW-1:0] o_scnt[4];
  logic [EW-1:0] o_se[4];

  initial begin
    vecs[0] = '{16'h0040, 5'd9,  10'd10,  16'h8000, 10'd1,   1'b0};
    vecs[1] = '{16'h0040, 5'd8,  10'd10,  16'h8000, 10'd1,   1'b0};
    vecs[2] = '{16'h0000, 5'd16, 10'd5,   16'h0000, 10'd0,   1'b1};
    vecs[3] = '{16'h8001, 5'd0,  10'd3,   16'h8001, 10'd3,   1'b0};
    vecs[4] = '{16'h0001, 5'd15, 10'd0,   16'h8000, 10'h3F1, 1'b0};
    vecs[5] = '{16'h0001, 5'd14, 10'd0,   16'h8000, 10'h3F1, 1'b0};
    vecs[6] = '{16'h1234, 5'd3,  10'd100, 16'h91A0, 10'd97,  1'b0};
    vecs[7] = '{16'h0000, 5'd0,  10'd7,   16'h0000, 10'd0,   1'b1};
    vecs[8] = '{16'h7FFF, 5'd0,  10'd0,   16'hFFFE, 10'h3FF, 1'b0};

    // Reset state
    #1 resetn = 1'b0;
    #1;
    check("rst_outvalid", 32'(OutValid), 32'(0));
    check("rst_mf", 32'(Mf), 32'(0));
    check("rst_me", 32'(Me), 32'(0));
    check("rst_sumzero", 32'(SumZero), 32'(0));
    check("rst_inready", 32'(InReady), 32'(1));
    #10 resetn = 1'b1;
    tick();

    // Directed table, one op at a time, latency measured in edges
    OutReady = 1'b1;
    for (int i = 0; i < 9; i++) begin
      Sm = vecs[i].sm; SCnt = vecs[i].scnt; Se = vecs[i].se; InValid = 1'b1;
      tick();
      InValid = 1'b0;
      found = 1'b0;
      for (int k = 1; k <= 6 && !found; k++) begin
        @(negedge clk);
        if (OutValid) begin
          found = 1'b1;
          $display("vec %0d: Sm=%h SCnt=%0d Se=%h -> Mf=%h Me=%h SumZero=%0d lat=%0d",
                   i, vecs[i].sm, vecs[i].scnt, vecs[i].se, Mf, Me, SumZero, k);
          check($sformatf("dir%0d_latency", i), 32'(k), 32'(2));
          check($sformatf("dir%0d_mf", i), 32'(Mf), 32'(vecs[i].mf));
          check($sformatf("dir%0d_me", i), 32'(Me), 32'(vecs[i].me));
          check($sformatf("dir%0d_zero", i), 32'(SumZero), 32'(vecs[i].zero));
        end
      end
      check($sformatf("dir%0d_timeout", i), 32'(found), 32'(1));
      tick();
    end

    // Back-to-back ops into a stalled pipe
    for (int i = 0; i < 4; i++) rand_op(o_sm[i], o_scnt[i], o_se[i]);
    cnt0 = out_count;
    OutReady = 1'b0;
    Sm = o_sm[0]; SCnt = o_scnt[0]; Se = o_se[0]; InValid = 1'b1;
    @(negedge clk) check("stall_rdy0", 32'(InReady), 32'(1));
    tick();
    Sm = o_sm[1]; SCnt = o_scnt[1]; Se = o_se[1];
    @(negedge clk) check("stall_rdy1", 32'(InReady), 32'(1));
    tick();
    Sm = o_sm[2]; SCnt = o_scnt[2]; Se = o_se[2];
    @(negedge clk);
    check("stall_rdy2", 32'(InReady), 32'(0));
    check("stall_outvalid", 32'(OutValid), 32'(1));
    held_mf = Mf;
    held_me = Me;
    tick();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("stall_hold_mf", 32'(Mf), 32'(held_mf));
      check("stall_hold_me", 32'(Me), 32'(held_me));
      check("stall_hold_rdy", 32'(InReady), 32'(0));
      tick();
    end
    OutReady = 1'b1;
    @(negedge clk) check("stall_resume_rdy", 32'(InReady), 32'(1));
    tick();
    Sm = o_sm[3]; SCnt = o_scnt[3]; Se = o_se[3];
    tick();
    InValid = 1'b0;
    repeat (5) tick();
    check("stall_out_count", 32'(out_count - cnt0), 32'(4));
    check("stall_queue_empty", 32'(exp_q.size()), 32'(0));

    // Flush with both stages full and a new input offered
    OutReady = 1'b0;
    Sm = vecs[0].sm; SCnt = vecs[0].scnt; Se = vecs[0].se; InValid = 1'b1;
    tick();
    Sm = vecs[6].sm; SCnt = vecs[6].scnt; Se = vecs[6].se;
    tick();
    Sm = vecs[8].sm; SCnt = vecs[8].scnt; Se = vecs[8].se; Flush = 1'b1;
    @(negedge clk) check("flush_pre_outvalid", 32'(OutValid), 32'(1));
    tick();
    Flush = 1'b0; InValid = 1'b0;
    check("flush_outvalid", 32'(OutValid), 32'(0));
    cnt0 = out_count;
    OutReady = 1'b1;
    repeat (4) tick();
    check("flush_no_output", 32'(out_count - cnt0), 32'(0));
    check("flush_outvalid_after", 32'(OutValid), 32'(0));

    // Asynchronous reset mid-stream
    Sm = vecs[0].sm; SCnt = vecs[0].scnt; Se = vecs[0].se; InValid = 1'b1;
    repeat (3) tick();
    #2;
    resetn = 1'b0; InValid = 1'b0;
    #1;
    check("midrst_outvalid", 32'(OutValid), 32'(0));
    check("midrst_mf", 32'(Mf), 32'(0));
    check("midrst_me", 32'(Me), 32'(0));
    @(posedge clk);
    #3 resetn = 1'b1;
    tick();
    check("midrst_after_outvalid", 32'(OutValid), 32'(0));

    // Randomized traffic against the reference scoreboard
    for (int i = 0; i < 400; i++) begin
      rand_op(Sm, SCnt, Se);
      InValid  = ($urandom_range(0, 9) < 7);
      OutReady = ($urandom_range(0, 9) < 7);
      Flush    = ($urandom_range(0, 49) == 0);
      tick();
    end
    Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    repeat (5) tick();
    check("rand_queue_empty", 32'(exp_q.size()), 32'(0));
    check("rand_outvalid_idle", 32'(OutValid), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
